// File: rtl/hps_ext_host_if.sv
// hps_ext_host_if
//   Core-side request / payload / response bundle of the EXT_BUS host.
//   master : core-side sequencer (issues requests, supplies payload, takes responses)
//   slave  : hps_ext_host
//   Signals: req_valid/req_ready/req_cmd/req_len/req_rd_only  command request
//            wr_valid/wr_data/wr_ready                          payload stream
//            rd_valid/rd_index/rd_data                          response words
//            resp_en, done                                      transaction status
interface hps_ext_host_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_cmd;
    logic [4:0]  req_len;
    logic        req_rd_only;
    logic        wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [4:0]  rd_index;
    logic [15:0] rd_data;
    logic        resp_en;
    logic        done;

    modport master (
        output req_valid, req_cmd, req_len, req_rd_only, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_index, rd_data, resp_en, done
    );

    modport slave (
        input  req_valid, req_cmd, req_len, req_rd_only, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_index, rd_data, resp_en, done
    );
endinterface

// File: rtl/hps_ext_host.sv
// hps_ext_host
//   FPGA-side initiator for the EXT_BUS command protocol. Sends one command word
//   followed by req_len payload words, paced by io_strobe and bracketed by io_enable,
//   and returns every response word the responder places on io_dout.
//
//   Ports:
//     clk_sys   system clock
//     reset_n   asynchronous active-low reset
//     core      hps_ext_host_if.slave (request, payload and response streams)
//     EXT_BUS   [31:16] io_din, [33] io_strobe, [34] io_enable driven here;
//               [15:0] io_dout and [32] dout_en sampled; [35] unused.
//               Bits not driven here are left to the responder.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | enable low, req_ready high, waiting for a request
//   S_OPEN   | enable high for one cycle before the first strobe
//   S_STROBE | one strobe cycle; io_din holds the current word
//   S_GAP    | STROBE_GAP idle cycles; response captured in the first one;
//            | waits here (enable held) while the next payload word is missing
//   S_CLOSE  | enable low for one cycle, done pulse
module hps_ext_host #(
    parameter int STROBE_GAP = 2,   // 1..15
    parameter int MAX_LEN    = 31
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    hps_ext_host_if.slave     core,
    inout  wire  [35:0]       EXT_BUS
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPEN,
        S_STROBE,
        S_GAP,
        S_CLOSE
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(STROBE_GAP - 1);
    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);

    state_t      state_q;
    logic [15:0] cmd_q;
    logic [4:0]  len_q;
    logic        rd_only_q;
    logic [5:0]  k_q;          // words already strobed, 0..32
    logic [3:0]  gap_q;
    logic        cap_q;        // next GAP cycle is the first after a strobe
    logic [15:0] din_q;
    logic        strobe_q;
    logic        enable_q;
    logic        req_ready_q;
    logic        wr_ready_q;
    logic        rd_valid_q;
    logic [4:0]  rd_index_q;
    logic [15:0] rd_data_q;
    logic        resp_en_q;
    logic        done_q;

    logic [4:0]  len_d;
    logic [5:0]  len_over;
    logic [15:0] word_d;
    logic        more_words;
    logic        pay_ok;
    logic        unused_bus;

    always_comb begin
        // borrow out of MAX_LEN - req_len flags an over-long request
        len_over   = 6'(MAX_LEN) - {1'b0, core.req_len};
        len_d      = len_over[5] ? LEN_MAX : core.req_len;
        word_d     = rd_only_q ? 16'h0000 : core.wr_data;
        more_words = ({1'b0, len_q} >= k_q);
        pay_ok     = rd_only_q | core.wr_valid;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            len_q       <= '0;
            rd_only_q   <= 1'b0;
            k_q         <= '0;
            gap_q       <= '0;
            cap_q       <= 1'b0;
            din_q       <= '0;
            strobe_q    <= 1'b0;
            enable_q    <= 1'b0;
            req_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_index_q  <= '0;
            rd_data_q   <= '0;
            resp_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (core.req_valid && req_ready_q) begin
                        cmd_q       <= core.req_cmd;
                        len_q       <= len_d;
                        rd_only_q   <= core.req_rd_only;
                        resp_en_q   <= 1'b0;
                        k_q         <= '0;
                        req_ready_q <= 1'b0;
                        enable_q    <= 1'b1;
                        state_q     <= S_OPEN;
                    end
                end
                S_OPEN: begin
                    strobe_q <= 1'b1;
                    din_q    <= cmd_q;
                    state_q  <= S_STROBE;
                end
                S_STROBE: begin
                    strobe_q   <= 1'b0;
                    wr_ready_q <= 1'b0;
                    k_q        <= k_q + 6'd1;
                    gap_q      <= GAP_LAST;
                    cap_q      <= 1'b1;
                    state_q    <= S_GAP;
                end
                S_GAP: begin
                    // responder updated io_dout on the strobe edge; it is stable now
                    if (cap_q) begin
                        cap_q      <= 1'b0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= EXT_BUS[15:0];
                        rd_index_q <= 5'(k_q - 6'd1);
                        if (k_q == 6'd1) begin
                            resp_en_q <= EXT_BUS[32];
                        end
                    end
                    if (gap_q != 4'd0) begin
                        gap_q <= gap_q - 4'd1;
                    end else if (!more_words) begin
                        enable_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_CLOSE;
                    end else if (pay_ok) begin
                        // word is registered now and popped from the source
                        // while it is on the bus
                        strobe_q   <= 1'b1;
                        din_q      <= word_d;
                        wr_ready_q <= ~rd_only_q;
                        state_q    <= S_STROBE;
                    end
                end
                S_CLOSE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign EXT_BUS[31:16] = din_q;
    assign EXT_BUS[33]    = strobe_q;
    assign EXT_BUS[34]    = enable_q;
    assign unused_bus     = ^EXT_BUS;

    assign core.req_ready = req_ready_q;
    assign core.wr_ready  = wr_ready_q;
    assign core.rd_valid  = rd_valid_q;
    assign core.rd_index  = rd_index_q;
    assign core.rd_data   = rd_data_q;
    assign core.resp_en   = resp_en_q;
    assign core.done      = done_q;

endmodule

// File: tb/tb_hps_ext_host.sv
module tb_hps_ext_host;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    hps_ext_host_if core_if();
    wire [35:0] ext_bus;

    hps_ext_host #(.STROBE_GAP(2), .MAX_LEN(31)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .core    (core_if),
        .EXT_BUS (ext_bus)
    );

    wire [15:0] bus_din    = ext_bus[31:16];
    wire        bus_strobe = ext_bus[33];
    wire        bus_enable = ext_bus[34];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // ---------------- responder model ----------------
    logic [15:0] r_dout        = '0;
    logic        r_dout_en     = 1'b0;
    logic [4:0]  r_cnt         = '0;
    logic [15:0] r_cmd         = '0;
    logic        lz4_ab        = 1'b0;
    logic [31:0] lz4_size      = '0;
    logic        cmd_blit_lz4  = 1'b0;
    logic        cmd_switchres = 1'b0;
    logic [31:0] vga_frame     = 32'h0001_2345;

    assign ext_bus[15:0] = r_dout;
    assign ext_bus[32]   = r_dout_en;

    always @(posedge clk_sys) begin
        if (!bus_enable) begin
            r_cnt     <= '0;
            r_dout    <= '0;
            r_dout_en <= 1'b0;
        end else if (bus_strobe) begin
            if (r_cnt != 5'd31) r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd0) begin
                r_cmd <= bus_din;
                if (bus_din == 16'h00F0 || bus_din == 16'h00F3 || bus_din == 16'h00F7) begin
                    r_dout_en <= 1'b1;
                    r_dout    <= 16'h00A5;
                end else begin
                    r_dout_en <= 1'b0;
                    r_dout    <= 16'h0000;
                end
                if (bus_din == 16'h00F7) cmd_blit_lz4 <= 1'b0;
            end else begin
                r_dout <= 16'h0000;
                case (r_cmd)
                    16'h00F0: begin
                        if (r_cnt == 5'd1) r_dout <= vga_frame[15:0];
                        if (r_cnt == 5'd2) r_dout <= vga_frame[31:16];
                    end
                    16'h00F7: begin
                        if (r_cnt == 5'd1) lz4_ab <= bus_din[0];
                        if (r_cnt == 5'd2) lz4_size[15:0] <= bus_din;
                        if (r_cnt == 5'd3) begin
                            lz4_size[31:16] <= bus_din;
                            cmd_blit_lz4    <= 1'b1;
                        end
                    end
                    16'h00F3: begin
                        if (r_cnt == 5'd1) cmd_switchres <= bus_din[0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    int          rd_cnt = 0, done_cnt = 0, strobe_cnt = 0, en_hi = 0, done_cyc = 0;
    int          low_run = 0, last_low_run = 0;
    logic        prev_en = 1'b0;
    logic [15:0] din_or = '0;
    logic [15:0] rd_mem [0:31];
    logic [15:0] w0_q [$];

    always @(negedge clk_sys) begin
        if (core_if.rd_valid) begin
            rd_cnt++;
            rd_mem[core_if.rd_index] = core_if.rd_data;
            if (core_if.rd_index == 5'd0) w0_q.push_back(core_if.rd_data);
        end
        if (core_if.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus_strobe) begin
            if (strobe_cnt > 0) din_or = din_or | bus_din;
            strobe_cnt++;
        end
        if (bus_enable) begin
            en_hi++;
            if (!prev_en) last_low_run = low_run;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_en = bus_enable;
    end

    // ---------------- payload source ----------------
    logic [15:0] wq [$];
    int pop_cnt = 0, stall_at = -1, stall_left = 0;

    always @(negedge clk_sys) begin
        if (core_if.wr_valid && core_if.wr_ready && wq.size() > 0) begin
            wq.delete(0);
            pop_cnt++;
        end
        if (pop_cnt == stall_at && stall_left > 0) begin
            core_if.wr_valid = 1'b0;
            stall_left--;
        end else begin
            core_if.wr_valid = (wq.size() > 0);
            core_if.wr_data  = (wq.size() > 0) ? wq[0] : 16'h0000;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic clear_mon();
        rd_cnt     = 0;
        strobe_cnt = 0;
        en_hi      = 0;
        din_or     = '0;
        w0_q.delete();
        for (int i = 0; i < 32; i++) rd_mem[i] = 16'hDEAD;
    endtask

    task automatic start_req(input logic [15:0] cmd, input logic [4:0] len, input logic rd_only);
        int n;
        tick();
        core_if.req_cmd     = cmd;
        core_if.req_len     = len;
        core_if.req_rd_only = rd_only;
        core_if.req_valid   = 1'b1;
        n = 0;
        while (!core_if.req_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (!core_if.req_ready) begin
            failures++;
            $display("FAIL accept_timeout cmd=%h req_ready=%b required 1", cmd, core_if.req_ready);
        end
        acc_cyc = cyc;
        tick();
        core_if.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL done_timeout done_cnt=%0d required %0d", done_cnt, target);
        end
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus_enable, bus_strobe} !== 2'b00) begin
            failures++;
            $display("FAIL reset_en_strobe got=%b required 00", {bus_enable, bus_strobe});
        end
        checks++;
        if (bus_din !== 16'h0000) begin
            failures++;
            $display("FAIL reset_io_din got=%h required 0000", bus_din);
        end
        checks++;
        if ({core_if.req_ready, core_if.wr_ready, core_if.rd_valid, core_if.resp_en, core_if.done} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_flags got=%b required 10000",
                     {core_if.req_ready, core_if.wr_ready, core_if.rd_valid, core_if.resp_en, core_if.done});
        end
        checks++;
        if ({core_if.rd_index, core_if.rd_data} !== 21'h0) begin
            failures++;
            $display("FAIL reset_rd got=%h/%h required 0/0000", core_if.rd_index, core_if.rd_data);
        end
        reset_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (core_if.req_ready !== 1'b1 || bus_enable !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle req_ready=%b enable=%b required 1/0", core_if.req_ready, bus_enable);
        end
    endtask

    task automatic test_groovy_status();
        int d0;
        clear_mon();
        d0 = done_cnt;
        wq.delete();
        wq.push_back(16'hBEEF);
        start_req(16'h00F0, 5'd9, 1'b1);
        wait_done(d0 + 1);
        checks++;
        if (rd_cnt !== 10) begin
            failures++;
            $display("FAIL groovy_rd_count got=%0d required 10", rd_cnt);
        end
        checks++;
        if (rd_mem[0] !== 16'h00A5) begin
            failures++;
            $display("FAIL groovy_word0 got=%h required 00a5", rd_mem[0]);
        end
        checks++;
        if (rd_mem[1] !== 16'h2345 || rd_mem[2] !== 16'h0001) begin
            failures++;
            $display("FAIL groovy_frame got=%h %h required 2345 0001", rd_mem[1], rd_mem[2]);
        end
        checks++;
        if (core_if.resp_en !== 1'b1) begin
            failures++;
            $display("FAIL groovy_resp_en got=%b required 1", core_if.resp_en);
        end
        checks++;
        if (done_cyc - acc_cyc !== 32) begin
            failures++;
            $display("FAIL groovy_latency got=%0d required 32", done_cyc - acc_cyc);
        end
        checks++;
        if (wq.size() !== 1 || din_or !== 16'h0000 || strobe_cnt !== 10) begin
            failures++;
            $display("FAIL groovy_rd_only wq=%0d din_or=%h strobes=%0d required 1 0000 10",
                     wq.size(), din_or, strobe_cnt);
        end
        wq.delete();
    endtask

    task automatic test_blit_lz4();
        int d0;
        clear_mon();
        d0 = done_cnt;
        pop_cnt = 0;
        wq.push_back(16'h0001);
        wq.push_back(16'h1234);
        wq.push_back(16'h0005);
        start_req(16'h00F7, 5'd3, 1'b0);
        wait_done(d0 + 1);
        checks++;
        if (lz4_ab !== 1'b1 || lz4_size !== 32'h0005_1234) begin
            failures++;
            $display("FAIL blit_payload ab=%b size=%h required 1 00051234", lz4_ab, lz4_size);
        end
        checks++;
        if (cmd_blit_lz4 !== 1'b1) begin
            failures++;
            $display("FAIL blit_cmd got=%b required 1", cmd_blit_lz4);
        end
        checks++;
        if (done_cyc - acc_cyc !== 14) begin
            failures++;
            $display("FAIL blit_latency got=%0d required 14", done_cyc - acc_cyc);
        end
        checks++;
        if (rd_cnt !== 4 || strobe_cnt !== 4 || wq.size() !== 0) begin
            failures++;
            $display("FAIL blit_counts rd=%0d strobes=%0d wq=%0d required 4 4 0", rd_cnt, strobe_cnt, wq.size());
        end
    endtask

    task automatic test_payload_stall();
        int d0;
        clear_mon();
        d0 = done_cnt;
        pop_cnt    = 0;
        stall_at   = 1;
        stall_left = 20;
        wq.push_back(16'h0001);
        wq.push_back(16'h1234);
        wq.push_back(16'h0005);
        start_req(16'h00F7, 5'd3, 1'b0);
        wait_done(d0 + 1);
        stall_at = -1;
        checks++;
        if (done_cyc - acc_cyc !== 32) begin
            failures++;
            $display("FAIL stall_latency got=%0d required 32", done_cyc - acc_cyc);
        end
        checks++;
        if (en_hi !== 31) begin
            failures++;
            $display("FAIL stall_enable_held high_cycles=%0d required 31", en_hi);
        end
        checks++;
        if (strobe_cnt !== 4) begin
            failures++;
            $display("FAIL stall_strobes got=%0d required 4", strobe_cnt);
        end
        checks++;
        if (lz4_size !== 32'h0005_1234 || lz4_ab !== 1'b1) begin
            failures++;
            $display("FAIL stall_payload size=%h ab=%b required 00051234 1", lz4_size, lz4_ab);
        end
    endtask

    task automatic test_unknown_cmd();
        int d0;
        clear_mon();
        d0 = done_cnt;
        start_req(16'h0010, 5'd0, 1'b1);
        wait_done(d0 + 1);
        checks++;
        if (rd_cnt !== 1 || rd_mem[0] !== 16'h0000) begin
            failures++;
            $display("FAIL unknown_rd count=%0d data=%h required 1 0000", rd_cnt, rd_mem[0]);
        end
        checks++;
        if (core_if.resp_en !== 1'b0 || core_if.rd_index !== 5'd0) begin
            failures++;
            $display("FAIL unknown_resp_en resp_en=%b idx=%0d required 0 0", core_if.resp_en, core_if.rd_index);
        end
        checks++;
        if (done_cyc - acc_cyc !== 5) begin
            failures++;
            $display("FAIL unknown_latency got=%0d required 5", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_reset_mid_payload();
        int d0;
        int n;
        clear_mon();
        d0 = done_cnt;
        pop_cnt = 0;
        wq.push_back(16'h0001);
        wq.push_back(16'h1234);
        wq.push_back(16'h0005);
        start_req(16'h00F7, 5'd3, 1'b0);
        n = 0;
        while (pop_cnt < 1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (pop_cnt < 1) begin
            failures++;
            $display("FAIL rstmid_word1_timeout pop_cnt=%0d required 1", pop_cnt);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_enable, bus_strobe} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_async_drop en_strobe=%b required 00", {bus_enable, bus_strobe});
        end
        wq.delete();
        repeat (5) tick();
        checks++;
        if (done_cnt !== d0) begin
            failures++;
            $display("FAIL rstmid_no_done done_cnt=%0d required %0d", done_cnt, d0);
        end
        reset_n = 1'b1;
        tick();
        clear_mon();
        d0 = done_cnt;
        wq.push_back(16'h0001);
        start_req(16'h00F3, 5'd1, 1'b0);
        wait_done(d0 + 1);
        checks++;
        if (cmd_switchres !== 1'b1 || core_if.resp_en !== 1'b1) begin
            failures++;
            $display("FAIL switchres got=%b resp_en=%b required 1 1", cmd_switchres, core_if.resp_en);
        end
        checks++;
        if (done_cyc - acc_cyc !== 8) begin
            failures++;
            $display("FAIL switchres_latency got=%0d required 8", done_cyc - acc_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        int acc;
        int n;
        clear_mon();
        d0 = done_cnt;
        tick();
        core_if.req_cmd     = 16'h00F0;
        core_if.req_len     = 5'd0;
        core_if.req_rd_only = 1'b1;
        core_if.req_valid   = 1'b1;
        acc = 0;
        n   = 0;
        while (acc < 2 && n < 200) begin
            if (core_if.req_ready) acc++;
            if (acc < 2) begin
                tick();
                n++;
            end
        end
        tick();
        core_if.req_valid = 1'b0;
        wait_done(d0 + 2);
        repeat (4) tick();
        checks++;
        if (done_cnt !== d0 + 2) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d required %0d", done_cnt - d0, 2);
        end
        checks++;
        if (last_low_run !== 2) begin
            failures++;
            $display("FAIL b2b_enable_low got=%0d required 2", last_low_run);
        end
        checks++;
        if (w0_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_word0_count got=%0d required 2", w0_q.size());
        end else if (w0_q[0] !== 16'h00A5 || (w0_q[1] - w0_q[0]) !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_word0 got=%h %h required 00a5 00a5", w0_q[0], w0_q[1]);
        end
    endtask

    initial begin
        core_if.req_valid   = 1'b0;
        core_if.req_cmd     = '0;
        core_if.req_len     = '0;
        core_if.req_rd_only = 1'b0;
        core_if.wr_valid    = 1'b0;
        core_if.wr_data     = '0;
        for (int i = 0; i < 32; i++) rd_mem[i] = 16'hDEAD;

        test_reset();
        test_groovy_status();
        test_blit_lz4();
        test_payload_stall();
        test_unknown_cmd();
        test_reset_mid_payload();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
